// File: rtl/phase_sweep_ctrl.sv
// Frequency-sweep sequencer for the phase accumulator: steps the increment word
// from f_start to f_stop, holding each value for a programmable dwell.
module phase_sweep_ctrl #(
    parameter int WIDTH   = 14,
    parameter int DWELL_W = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic                    repeat_i,
    input  logic signed [WIDTH-1:0] f_start_i,
    input  logic signed [WIDTH-1:0] f_stop_i,
    input  logic        [WIDTH-2:0] f_step_i,
    input  logic      [DWELL_W-1:0] dwell_i,
    output logic signed [WIDTH-1:0] freq_o,
    output logic                    acc_clr_o,
    output logic                    busy_o,
    output logic                    done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DWELL = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic signed [WIDTH-1:0] f_start_q;
    logic signed [WIDTH-1:0] f_stop_q;
    logic        [WIDTH-2:0] f_step_q;
    logic      [DWELL_W-1:0] dwell_q;
    logic                    repeat_q;
    logic                    up_q;
    logic      [DWELL_W-1:0] cnt_q, cnt_d;

    logic signed [WIDTH-1:0] freq_d;
    logic                    clr_d;
    logic                    busy_d;
    logic                    done_d;

    logic accept;
    logic dwell_end;
    logic at_stop;

    // A dwell of zero would never expire; it is held as one cycle instead.
    function automatic logic [DWELL_W-1:0] dwell_len(input logic [DWELL_W-1:0] d);
        return (d == '0) ? DWELL_W'(1) : d;
    endfunction

    // Step one increment toward stop in WIDTH+1 bits and saturate at stop, so the
    // word can never wrap. A zero step counts as overshoot and lands on stop.
    function automatic logic signed [WIDTH-1:0] next_freq(
        input logic signed [WIDTH-1:0] cur,
        input logic signed [WIDTH-1:0] stop,
        input logic        [WIDTH-2:0] step,
        input logic                    up
    );
        logic signed [WIDTH:0] cur_x;
        logic signed [WIDTH:0] stop_x;
        logic signed [WIDTH:0] step_x;
        logic signed [WIDTH:0] sum_x;
        cur_x  = $signed({cur[WIDTH-1], cur});
        stop_x = $signed({stop[WIDTH-1], stop});
        step_x = $signed({2'b00, step});
        sum_x  = up ? (cur_x + step_x) : (cur_x - step_x);
        if (step == '0)
            return stop;
        if (up ? (sum_x > stop_x) : (sum_x < stop_x))
            return stop;
        return $signed(sum_x[WIDTH-1:0]);
    endfunction

    assign accept    = (state_q == S_IDLE) && start_i && !abort_i;
    assign dwell_end = (cnt_q == dwell_q);
    assign at_stop   = (freq_o == f_stop_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept)
                    state_d = S_CLEAR;
            end
            S_CLEAR, S_DWELL: begin
                if (abort_i)
                    state_d = S_IDLE;
                else if (dwell_end && at_stop)
                    state_d = repeat_q ? S_CLEAR : S_IDLE;
                else
                    state_d = S_DWELL;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and dwell counter.
    always_comb begin
        freq_d = freq_o;
        clr_d  = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        cnt_d  = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    freq_d = f_start_i;
                    clr_d  = 1'b1;
                    busy_d = 1'b1;
                    cnt_d  = DWELL_W'(1);
                end
            end
            S_CLEAR, S_DWELL: begin
                if (abort_i) begin
                    freq_d = '0;
                    cnt_d  = '0;
                end else if (!dwell_end) begin
                    busy_d = 1'b1;
                    cnt_d  = cnt_q + DWELL_W'(1);
                end else if (!at_stop) begin
                    busy_d = 1'b1;
                    freq_d = next_freq(freq_o, f_stop_q, f_step_q, up_q);
                    cnt_d  = DWELL_W'(1);
                end else if (repeat_q) begin
                    busy_d = 1'b1;
                    clr_d  = 1'b1;
                    freq_d = f_start_q;
                    cnt_d  = DWELL_W'(1);
                end else begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                end
            end
            default: begin
                freq_d = '0;
                cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            freq_o    <= '0;
            acc_clr_o <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            freq_o    <= freq_d;
            acc_clr_o <= clr_d;
            busy_o    <= busy_d;
            done_o    <= done_d;
            cnt_q     <= cnt_d;
        end
    end

    // Configuration is frozen on the accepting edge; later input changes are ignored.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            f_start_q <= '0;
            f_stop_q  <= '0;
            f_step_q  <= '0;
            dwell_q   <= DWELL_W'(1);
            repeat_q  <= 1'b0;
            up_q      <= 1'b1;
        end else if (accept) begin
            f_start_q <= f_start_i;
            f_stop_q  <= f_stop_i;
            f_step_q  <= f_step_i;
            dwell_q   <= dwell_len(dwell_i);
            repeat_q  <= repeat_i;
            up_q      <= (f_stop_i >= f_start_i);
        end
    end

endmodule

// File: tb/tb_phase_sweep_ctrl.sv
// Directed bench for phase_sweep_ctrl: sweep sequences, saturation, repeat,
// abort, reset and start-while-busy.
module tb_phase_sweep_ctrl;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               start_i;
    logic               abort_i;
    logic               repeat_i;
    logic signed [13:0] f_start_i;
    logic signed [13:0] f_stop_i;
    logic        [12:0] f_step_i;
    logic        [15:0] dwell_i;
    logic signed [13:0] freq_o;
    logic               acc_clr_o;
    logic               busy_o;
    logic               done_o;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    bit poke_start = 1'b0;

    phase_sweep_ctrl #(.WIDTH(14), .DWELL_W(16)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .abort_i  (abort_i),
        .repeat_i (repeat_i),
        .f_start_i(f_start_i),
        .f_stop_i (f_stop_i),
        .f_step_i (f_step_i),
        .dwell_i  (dwell_i),
        .freq_o   (freq_o),
        .acc_clr_o(acc_clr_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cyc(input string tag, input int f, input int clr, input int busy, input int done);
        chk({tag, "/freq"}, freq_o, f);
        chk({tag, "/clr"}, acc_clr_o, clr);
        chk({tag, "/busy"}, busy_o, busy);
        chk({tag, "/done"}, done_o, done);
    endtask

    // Pulse start with the given config, then scramble the inputs to prove they were latched.
    task automatic start_sweep(input int fs, input int fe, input int st, input int dw, input bit rp);
        f_start_i = 14'(fs);
        f_stop_i  = 14'(fe);
        f_step_i  = 13'(st);
        dwell_i   = 16'(dw);
        repeat_i  = rp;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
        f_start_i = -14'sd1234;
        f_stop_i  = 14'sd777;
        f_step_i  = 13'd1;
        dwell_i   = 16'd9;
        repeat_i  = ~rp;
    endtask

    task automatic check_pass(input string tag, input int d);
        for (int i = 0; i < exp_q.size(); i++) begin
            for (int k = 0; k < d; k++) begin
                cyc($sformatf("%s[%0d.%0d]", tag, i, k), exp_q[i], (i == 0 && k == 0) ? 1 : 0, 1, 0);
                if (poke_start && i == 1 && k == 0) begin
                    start_i   = 1'b1;
                    f_start_i = 14'sd500;
                end
                tick();
                start_i = 1'b0;
            end
        end
    endtask

    task automatic check_done(input string tag, input int last);
        cyc({tag, "/done"}, last, 0, 0, 1);
        tick();
        cyc({tag, "/after"}, last, 0, 0, 0);
    endtask

    initial begin
        rst_i     = 1'b1;
        start_i   = 1'b0;
        abort_i   = 1'b0;
        repeat_i  = 1'b0;
        f_start_i = '0;
        f_stop_i  = '0;
        f_step_i  = '0;
        dwell_i   = '0;
        #12;
        cyc("reset", 0, 0, 0, 0);
        rst_i = 1'b0;
        tick();
        cyc("idle", 0, 0, 0, 0);

        start_sweep(100, 130, 10, 3, 1'b0);
        exp_q = '{100, 110, 120, 130};
        check_pass("up", 3);
        check_done("up", 130);

        start_sweep(0, 25, 10, 0, 1'b0);
        exp_q = '{0, 10, 20, 25};
        check_pass("ovs", 1);
        check_done("ovs", 25);

        start_sweep(50, -50, 40, 2, 1'b0);
        exp_q = '{50, 10, -30, -50};
        check_pass("down", 2);
        check_done("down", -50);

        start_sweep(8000, 8191, 100, 1, 1'b0);
        exp_q = '{8000, 8100, 8191};
        check_pass("edge", 1);
        check_done("edge", 8191);

        start_sweep(100, -100, 0, 1, 1'b0);
        exp_q = '{100, -100};
        check_pass("step0", 1);
        check_done("step0", -100);

        start_sweep(0, 20, 10, 1, 1'b1);
        exp_q = '{0, 10, 20};
        check_pass("rep1", 1);
        check_pass("rep2", 1);
        cyc("rep3", 0, 1, 1, 0);
        tick();
        cyc("rep3b", 10, 0, 1, 0);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        cyc("abort", 0, 0, 0, 0);
        tick();
        cyc("abort_idle", 0, 0, 0, 0);

        start_sweep(7, 7, 5, 1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc($sformatf("same[%0d]", i), 7, 1, 1, 0);
            tick();
        end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        cyc("same_abort", 0, 0, 0, 0);

        start_i   = 1'b1;
        abort_i   = 1'b1;
        f_start_i = 14'sd300;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        cyc("abort_wins", 0, 0, 0, 0);
        tick();
        cyc("abort_wins2", 0, 0, 0, 0);

        start_sweep(0, 30, 10, 2, 1'b0);
        exp_q = '{0, 10, 20, 30};
        poke_start = 1'b1;
        check_pass("busy_start", 2);
        poke_start = 1'b0;
        check_done("busy_start", 30);

        start_sweep(100, 200, 10, 4, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        cyc("pre_rst", 110, 0, 1, 0);
        #3;
        rst_i = 1'b1;
        #1;
        cyc("async_rst", 0, 0, 0, 0);
        tick();
        cyc("rst_hold", 0, 0, 0, 0);
        rst_i = 1'b0;
        tick();
        cyc("rst_idle", 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phase_sweep_ctrl.md
Name: phase_sweep_ctrl

Overview:
- Sequencer that drives the increment (frequency word) input of the phase accumulator.
- Steps the increment from a start value to a stop value in fixed-size steps. Each value is held for a programmable dwell.
- Issues a one-cycle clear to the accumulator at the start of each sweep pass.
- Sits between the register interface (config, start/abort) and the accumulator's data_i / rst_i.

Parameters:
- WIDTH, 14, width of signed frequency word; matches accumulator width.
- DWELL_W, 16, width of dwell counter and dwell_i.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset, asynchronous, active-high.
- start_i  input  1  start a sweep; sampled only in IDLE.
- abort_i  input  1  stop the sweep immediately.
- repeat_i  input  1  0 = one-shot, 1 = restart from f_start after each pass; latched at start.
- f_start_i  input  WIDTH  signed first frequency word.
- f_stop_i  input  WIDTH  signed last frequency word.
- f_step_i  input  WIDTH-1  unsigned step magnitude.
- dwell_i  input  DWELL_W  cycles per value; 0 is treated as 1.
- freq_o  output  WIDTH  signed registered frequency word to accumulator data_i.
- acc_clr_o  output  1  registered one-cycle accumulator clear.
- busy_o  output  1  high while sweeping.
- done_o  output  1  one-cycle pulse at end of a one-shot sweep.

Behaviour:
- Reset: IDLE, freq_o=0, acc_clr_o=0, busy_o=0, done_o=0, dwell counter=0. Asserting reset mid-sweep returns to this state immediately.
- States:
  - IDLE
  - CLEAR: first cycle of each pass.
  - DWELL
- Latching: all config inputs (f_start, f_stop, f_step, dwell, repeat) are latched on the edge that accepts start. Input changes during a sweep have no effect.
- Direction: up if f_stop >= f_start (signed), else down. Fixed for the sweep.
- IDLE, start_i=1, abort_i=0: next cycle is CLEAR.
  - freq_o=f_start, acc_clr_o=1, busy_o=1.
- CLEAR counts as cycle 1 of f_start's dwell. Next state is DWELL, or CLEAR again if D=1 and repeat applies.
- Hold time: every frequency value is visible on freq_o for exactly D = max(dwell_i,1) cycles.
- End of a dwell, current value != f_stop:
  - freq_o <= current ± step, computed in WIDTH+1 bits.
  - If the result passes f_stop, freq_o <= f_stop. freq_o never wraps.
  - step=0 counts as overshoot: freq_o jumps directly to f_stop.
- End of f_stop's dwell:
  - repeat=1: next cycle is CLEAR (freq_o=f_start, acc_clr_o=1). No done_o.
  - repeat=0: next cycle is IDLE with done_o=1 for one cycle and busy_o=0. freq_o keeps f_stop until the next start or reset.
- f_start == f_stop: single value held D cycles, then completion as above.
- abort_i while busy: next cycle is IDLE, freq_o=0, acc_clr_o=0, busy_o=0, no done_o.
- abort_i and start_i together in IDLE: abort wins, block stays IDLE.
- start_i while busy: ignored.
- acc_clr_o is high only in CLEAR.

Test Plan:
- Up sweep: start=100, stop=130, step=10, dwell=3, repeat=0, start pulsed at edge 0 -> freq_o 100 on cycles 1-3 (acc_clr_o=1 on cycle 1 only), 110 on 4-6, 120 on 7-9, 130 on 10-12; cycle 13: done_o=1, busy_o=0, freq_o=130.
- Overshoot and dwell=0: start=0, stop=25, step=10, dwell=0 -> freq_o 0, 10, 20, 25 one cycle each, then done_o; no value exceeds 25.
- Down sweep, signed: start=50, stop=-50, step=40, dwell=2 -> 50,50,10,10,-30,-30,-50,-50 then done_o.
- Range edge: start=8000, stop=8191, step=100, WIDTH=14 -> 8000, 8100, 8191; no wrap to negative.
- Repeat and abort: start=0, stop=20, step=10, dwell=1, repeat=1 -> 0,10,20,0,10,20... with acc_clr_o on each 0 cycle and no done_o. abort_i on a "10" cycle -> next cycle freq_o=0, busy_o=0, done_o=0.
- Async reset mid-sweep, plus start during busy: reset asserted mid-sweep -> outputs 0 immediately, block in IDLE. Start pulsed while busy -> freq_o sequence unchanged.
